// File: rtl/clock_set_controller.sv
// clock_set_controller
// Button-driven time/date editor for the clock_calendar chain. In IDLE it
// waits for btn_mode, then captures the live BCD digits and lets the user
// edit one field at a time with up/down. A second btn_mode commits the edit
// with a single-cycle load strobe. Thirty idle seconds abort the edit.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   tick_1hz               1 Hz single-cycle tick (drives the edit timeout)
//   btn_mode/next/up/down  debounced single-cycle button pulses
//                          (priority mode > next > up > down)
//   cur_*                  live am_pm and BCD time/date from the clock chain
//   set_active             high while editing
//   field_sel              0=AMPM 1=HOUR 2=MIN 3=SEC 4=YEAR 5=MONTH 6=DAY
//   blink                  edit highlight, toggles every BLINK_DIV cycles
//   load                   single-cycle commit strobe
//   set_*                  edited am_pm and BCD time/date (valid with load)
//
// Interface note: there is no valid/ready handshake here. load is a pure
// strobe; the receiving chain must accept set_* on the cycle load is high.
module clock_set_controller #(
    parameter int TIMEOUT_S = 30,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       cur_am_pm,
    input  logic [3:0] cur_sec_1d,
    input  logic [3:0] cur_sec_10d,
    input  logic [3:0] cur_min_1d,
    input  logic [3:0] cur_min_10d,
    input  logic [3:0] cur_hour_1d,
    input  logic [3:0] cur_hour_10d,
    input  logic [3:0] cur_d_1d,
    input  logic [3:0] cur_d_10d,
    input  logic [3:0] cur_m_1d,
    input  logic [3:0] cur_m_10d,
    input  logic [3:0] cur_y_1d,
    input  logic [3:0] cur_y_10d,
    input  logic [3:0] cur_c_1d,
    input  logic [3:0] cur_c_10d,
    output logic       set_active,
    output logic [2:0] field_sel,
    output logic       blink,
    output logic       load,
    output logic       set_am_pm,
    output logic [3:0] set_sec_1d,
    output logic [3:0] set_sec_10d,
    output logic [3:0] set_min_1d,
    output logic [3:0] set_min_10d,
    output logic [3:0] set_hour_1d,
    output logic [3:0] set_hour_10d,
    output logic [3:0] set_d_1d,
    output logic [3:0] set_d_10d,
    output logic [3:0] set_m_1d,
    output logic [3:0] set_m_10d,
    output logic [3:0] set_y_1d,
    output logic [3:0] set_y_10d,
    output logic [3:0] set_c_1d,
    output logic [3:0] set_c_10d
);

    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [2:0] F_AMPM  = 3'd0;
    localparam logic [2:0] F_HOUR  = 3'd1;
    localparam logic [2:0] F_MIN   = 3'd2;
    localparam logic [2:0] F_SEC   = 3'd3;
    localparam logic [2:0] F_YEAR  = 3'd4;
    localparam logic [2:0] F_MONTH = 3'd5;
    localparam logic [2:0] F_DAY   = 3'd6;

    typedef enum logic [0:0] {IDLE = 1'b0, EDIT = 1'b1} state_t;

    typedef struct packed {
        logic       am_pm;
        logic [3:0] hour_10d, hour_1d;
        logic [3:0] min_10d,  min_1d;
        logic [3:0] sec_10d,  sec_1d;
        logic [3:0] c_10d,    c_1d;
        logic [3:0] y_10d,    y_1d;
        logic [3:0] m_10d,    m_1d;
        logic [3:0] d_10d,    d_1d;
    } set_t;

    // Fields are edited as small binary numbers and converted back to BCD,
    // which keeps every digit legal regardless of which wrap is taken.
    function automatic logic [6:0] to_bin(input logic [3:0] t, input logic [3:0] o);
        return ({3'b000, t} * 7'd10) + {3'b000, o};
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Wrapping step within [lo, hi]; out-of-range inputs snap to an end.
    function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi, input logic up);
        if (up) return (v >= hi || v < lo) ? lo : v + 7'd1;
        else    return (v <= lo || v > hi) ? hi : v - 7'd1;
    endfunction

    // Two-digit year divisible by 4 is a leap year (no century rule).
    function automatic logic [6:0] max_day(input logic [6:0] m, input logic [6:0] y);
        case (m)
            7'd2:                     return ((y % 7'd4) == 7'd0) ? 7'd29 : 7'd28;
            7'd4, 7'd6, 7'd9, 7'd11:  return 7'd30;
            default:                  return 7'd31;
        endcase
    endfunction

    state_t        state, state_nxt;
    set_t          val_q, val_d;
    logic [2:0]    field_d;
    logic          active_d, blink_d, load_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    logic       any_btn, timeout_hit;
    logic [6:0] hour_b, min_b, sec_b, year_b, month_b, day_b, edit_b, lim;

    assign any_btn = btn_mode | btn_next | btn_up | btn_down;
    // A button pulse clears the counter, so it always beats a coinciding tick.
    assign timeout_hit = (state == EDIT) && !any_btn && tick_1hz &&
                         (tcnt_q == TW'(TIMEOUT_S - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_mode) state_nxt = EDIT;
            EDIT:    if (btn_mode || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values (registered below)
    always_comb begin
        val_d    = val_q;
        field_d  = field_sel;
        active_d = set_active;
        blink_d  = blink;
        load_d   = 1'b0;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        hour_b   = to_bin(val_q.hour_10d, val_q.hour_1d);
        min_b    = to_bin(val_q.min_10d, val_q.min_1d);
        sec_b    = to_bin(val_q.sec_10d, val_q.sec_1d);
        year_b   = to_bin(val_q.y_10d, val_q.y_1d);
        month_b  = to_bin(val_q.m_10d, val_q.m_1d);
        day_b    = to_bin(val_q.d_10d, val_q.d_1d);
        edit_b   = 7'd0;
        lim      = max_day(month_b, year_b);

        case (state)
            IDLE: begin
                if (btn_mode) begin
                    val_d = '{am_pm: cur_am_pm,
                              hour_10d: cur_hour_10d, hour_1d: cur_hour_1d,
                              min_10d: cur_min_10d, min_1d: cur_min_1d,
                              sec_10d: cur_sec_10d, sec_1d: cur_sec_1d,
                              c_10d: cur_c_10d, c_1d: cur_c_1d,
                              y_10d: cur_y_10d, y_1d: cur_y_1d,
                              m_10d: cur_m_10d, m_1d: cur_m_1d,
                              d_10d: cur_d_10d, d_1d: cur_d_1d};
                    field_d  = F_HOUR;
                    active_d = 1'b1;
                    blink_d  = 1'b0;
                    tcnt_d   = '0;
                    bcnt_d   = '0;
                end
            end
            EDIT: begin
                if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                    bcnt_d  = '0;
                    blink_d = ~blink;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end

                if (any_btn)       tcnt_d = '0;
                else if (tick_1hz) tcnt_d = tcnt_q + TW'(1);

                if (btn_mode) begin
                    load_d   = 1'b1;
                    active_d = 1'b0;
                    blink_d  = 1'b0;
                end else if (timeout_hit) begin
                    active_d = 1'b0;
                    blink_d  = 1'b0;
                end else if (btn_next) begin
                    field_d = (field_sel == F_DAY) ? F_AMPM : field_sel + 3'd1;
                end else if (btn_up || btn_down) begin
                    case (field_sel)
                        F_AMPM: val_d.am_pm = ~val_q.am_pm;
                        F_HOUR: begin
                            edit_b = step(hour_b, 7'd1, 7'd12, btn_up);
                            {val_d.hour_10d, val_d.hour_1d} = to_bcd(edit_b);
                        end
                        F_MIN: begin
                            edit_b = step(min_b, 7'd0, 7'd59, btn_up);
                            {val_d.min_10d, val_d.min_1d} = to_bcd(edit_b);
                        end
                        F_SEC: begin
                            edit_b = step(sec_b, 7'd0, 7'd59, btn_up);
                            {val_d.sec_10d, val_d.sec_1d} = to_bcd(edit_b);
                        end
                        F_YEAR: begin
                            edit_b = step(year_b, 7'd0, 7'd99, btn_up);
                            {val_d.y_10d, val_d.y_1d} = to_bcd(edit_b);
                            lim = max_day(month_b, edit_b);
                            if (day_b > lim) {val_d.d_10d, val_d.d_1d} = to_bcd(lim);
                        end
                        F_MONTH: begin
                            edit_b = step(month_b, 7'd1, 7'd12, btn_up);
                            {val_d.m_10d, val_d.m_1d} = to_bcd(edit_b);
                            lim = max_day(edit_b, year_b);
                            if (day_b > lim) {val_d.d_10d, val_d.d_1d} = to_bcd(lim);
                        end
                        F_DAY: begin
                            edit_b = step(day_b, 7'd1, lim, btn_up);
                            {val_d.d_10d, val_d.d_1d} = to_bcd(edit_b);
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q          <= '0;
            val_q.hour_10d <= 4'd1;
            val_q.hour_1d  <= 4'd2;
            val_q.m_1d     <= 4'd1;
            val_q.d_1d     <= 4'd1;
            field_sel      <= F_AMPM;
            set_active     <= 1'b0;
            blink          <= 1'b0;
            load           <= 1'b0;
            tcnt_q         <= '0;
            bcnt_q         <= '0;
        end else begin
            val_q      <= val_d;
            field_sel  <= field_d;
            set_active <= active_d;
            blink      <= blink_d;
            load       <= load_d;
            tcnt_q     <= tcnt_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign set_am_pm    = val_q.am_pm;
    assign set_hour_10d = val_q.hour_10d;
    assign set_hour_1d  = val_q.hour_1d;
    assign set_min_10d  = val_q.min_10d;
    assign set_min_1d   = val_q.min_1d;
    assign set_sec_10d  = val_q.sec_10d;
    assign set_sec_1d   = val_q.sec_1d;
    assign set_c_10d    = val_q.c_10d;
    assign set_c_1d     = val_q.c_1d;
    assign set_y_10d    = val_q.y_10d;
    assign set_y_1d     = val_q.y_1d;
    assign set_m_10d    = val_q.m_10d;
    assign set_m_1d     = val_q.m_1d;
    assign set_d_10d    = val_q.d_10d;
    assign set_d_1d     = val_q.d_1d;

endmodule

// File: tb/tb_clock_set_controller.sv
// Testbench for clock_set_controller: table-driven edit sequence, hand-written
// corner sequences (commit, timeout, priority, reset, blink) and a randomized
// run checked every cycle against an arithmetic reference model.
module tb_clock_set_controller;

    localparam int TO = 6;
    localparam int BD = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic tick_1hz = 1'b0;
    logic btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic cur_am_pm = 1'b0;
    logic [3:0] cur_sec_1d = '0, cur_sec_10d = '0, cur_min_1d = '0, cur_min_10d = '0;
    logic [3:0] cur_hour_1d = '0, cur_hour_10d = '0, cur_d_1d = '0, cur_d_10d = '0;
    logic [3:0] cur_m_1d = '0, cur_m_10d = '0, cur_y_1d = '0, cur_y_10d = '0;
    logic [3:0] cur_c_1d = '0, cur_c_10d = '0;
    logic set_active, blink, load, set_am_pm;
    logic [2:0] field_sel;
    logic [3:0] set_sec_1d, set_sec_10d, set_min_1d, set_min_10d, set_hour_1d, set_hour_10d;
    logic [3:0] set_d_1d, set_d_10d, set_m_1d, set_m_10d, set_y_1d, set_y_10d;
    logic [3:0] set_c_1d, set_c_10d;

    clock_set_controller #(.TIMEOUT_S(TO), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
        .cur_am_pm(cur_am_pm),
        .cur_sec_1d(cur_sec_1d), .cur_sec_10d(cur_sec_10d),
        .cur_min_1d(cur_min_1d), .cur_min_10d(cur_min_10d),
        .cur_hour_1d(cur_hour_1d), .cur_hour_10d(cur_hour_10d),
        .cur_d_1d(cur_d_1d), .cur_d_10d(cur_d_10d),
        .cur_m_1d(cur_m_1d), .cur_m_10d(cur_m_10d),
        .cur_y_1d(cur_y_1d), .cur_y_10d(cur_y_10d),
        .cur_c_1d(cur_c_1d), .cur_c_10d(cur_c_10d),
        .set_active(set_active), .field_sel(field_sel), .blink(blink), .load(load),
        .set_am_pm(set_am_pm),
        .set_sec_1d(set_sec_1d), .set_sec_10d(set_sec_10d),
        .set_min_1d(set_min_1d), .set_min_10d(set_min_10d),
        .set_hour_1d(set_hour_1d), .set_hour_10d(set_hour_10d),
        .set_d_1d(set_d_1d), .set_d_10d(set_d_10d),
        .set_m_1d(set_m_1d), .set_m_10d(set_m_10d),
        .set_y_1d(set_y_1d), .set_y_10d(set_y_10d),
        .set_c_1d(set_c_1d), .set_c_10d(set_c_10d)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int load_cnt = 0;

    // ---------------- reference model ----------------
    int days_tab [1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int c_ampm, c_hour, c_min, c_sec, c_cent, c_year, c_month, c_day;
    int m_edit, m_field, m_ampm, m_hour, m_min, m_sec, m_cent, m_year, m_month, m_day;
    int m_tcnt, m_ecyc, m_load;

    function automatic int dim(input int mo, input int y);
        return (mo == 2 && (y % 4) == 0) ? 29 : days_tab[mo];
    endfunction

    task automatic model_reset();
        m_edit = 0; m_field = 0; m_ampm = 0; m_hour = 12; m_min = 0; m_sec = 0;
        m_cent = 0; m_year = 0; m_month = 1; m_day = 1; m_tcnt = 0; m_ecyc = 0; m_load = 0;
    endtask

    task automatic model_step();
        int dlt;
        m_load = 0;
        if (reset) begin
            model_reset();
        end else if (m_edit == 0) begin
            if (btn_mode) begin
                m_ampm = c_ampm; m_hour = c_hour; m_min = c_min; m_sec = c_sec;
                m_cent = c_cent; m_year = c_year; m_month = c_month; m_day = c_day;
                m_edit = 1; m_field = 1; m_tcnt = 0; m_ecyc = 0;
            end
        end else begin
            m_ecyc++;
            if (btn_mode || btn_next || btn_up || btn_down) m_tcnt = 0;
            else if (tick_1hz) m_tcnt++;
            dlt = btn_up ? 1 : -1;
            if (btn_mode) begin
                m_load = 1; m_edit = 0;
            end else if (m_tcnt == TO) begin
                m_edit = 0;
            end else if (btn_next) begin
                m_field = (m_field + 1) % 7;
            end else if (btn_up || btn_down) begin
                case (m_field)
                    0: m_ampm = 1 - m_ampm;
                    1: m_hour = ((m_hour - 1 + dlt + 12) % 12) + 1;
                    2: m_min = (m_min + dlt + 60) % 60;
                    3: m_sec = (m_sec + dlt + 60) % 60;
                    4: begin
                        m_year = (m_year + dlt + 100) % 100;
                        if (m_day > dim(m_month, m_year)) m_day = dim(m_month, m_year);
                    end
                    5: begin
                        m_month = ((m_month - 1 + dlt + 12) % 12) + 1;
                        if (m_day > dim(m_month, m_year)) m_day = dim(m_month, m_year);
                    end
                    default: m_day = ((m_day - 1 + dlt + dim(m_month, m_year)) %
                                      dim(m_month, m_year)) + 1;
                endcase
            end
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int d2(input logic [3:0] t, input logic [3:0] o);
        return int'(t) * 10 + int'(o);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (load) load_cnt++;
    endtask

    task automatic press(input logic [3:0] b);
        {btn_mode, btn_next, btn_up, btn_down} = b;
        cyc();
        {btn_mode, btn_next, btn_up, btn_down} = 4'b0;
    endtask

    task automatic tick_press(input logic [3:0] b);
        tick_1hz = 1'b1;
        press(b);
        tick_1hz = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic set_cur(input int a, input int h, input int mi, input int s,
                           input int ce, input int y, input int mo, input int d);
        c_ampm = a; c_hour = h; c_min = mi; c_sec = s; c_cent = ce; c_year = y;
        c_month = mo; c_day = d;
        cur_am_pm = 1'(a);
        {cur_hour_10d, cur_hour_1d} = bcd(h);
        {cur_min_10d, cur_min_1d}   = bcd(mi);
        {cur_sec_10d, cur_sec_1d}   = bcd(s);
        {cur_c_10d, cur_c_1d}       = bcd(ce);
        {cur_y_10d, cur_y_1d}       = bcd(y);
        {cur_m_10d, cur_m_1d}       = bcd(mo);
        {cur_d_10d, cur_d_1d}       = bcd(d);
    endtask

    task automatic rand_cur();
        int y, mo;
        y  = $urandom_range(0, 99);
        mo = $urandom_range(1, 12);
        set_cur($urandom_range(0, 1), $urandom_range(1, 12), $urandom_range(0, 59),
                $urandom_range(0, 59), $urandom_range(0, 99), y, mo,
                $urandom_range(1, dim(mo, y)));
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int f, input int a, input int h, input int mi,
                                       input int y, input int mo, input int d,
                                       input int act, input int ld);
        return {8'(f), 8'(a), 8'(h), 8'(mi), 8'(y), 8'(mo), 8'(d), 4'(act), 4'(ld)};
    endfunction

    function automatic logic [63:0] dut_pk();
        return pk(int'(field_sel), int'(set_am_pm), d2(set_hour_10d, set_hour_1d),
                  d2(set_min_10d, set_min_1d), d2(set_y_10d, set_y_1d),
                  d2(set_m_10d, set_m_1d), d2(set_d_10d, set_d_1d),
                  int'(set_active), int'(load));
    endfunction

    task automatic check_all(input string name);
        logic [63:0] exp_v, act_v;
        exp_v = {1'b0, 1'(m_ampm), 3'(m_field), 1'(m_edit),
                 1'((m_edit != 0) ? ((m_ecyc / BD) % 2) : 0), 1'(m_load),
                 bcd(m_hour), bcd(m_min), bcd(m_sec), bcd(m_cent), bcd(m_year),
                 bcd(m_month), bcd(m_day)};
        act_v = {1'b0, set_am_pm, field_sel, set_active, blink, load,
                 set_hour_10d, set_hour_1d, set_min_10d, set_min_1d, set_sec_10d, set_sec_1d,
                 set_c_10d, set_c_1d, set_y_10d, set_y_1d, set_m_10d, set_m_1d,
                 set_d_10d, set_d_1d};
        check(name, act_v, exp_v);
    endtask

    typedef struct {
        logic [3:0] btn;  // {mode, next, up, down}
        int f, a, h, mi, y, mo, d, act, ld;
    } vec_t;

    vec_t tab [$];
    bit   quiet;

    initial begin
        // Edit sequence from AM 01:00:00 2024-02-29
        tab.push_back('{4'h1, 1, 0, 12, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h2, 1, 0, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h4, 2, 0, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h1, 2, 0, 1, 59, 24, 2, 29, 1, 0});
        tab.push_back('{4'h2, 2, 0, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h4, 3, 0, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h4, 4, 0, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h2, 4, 0, 1, 0, 25, 2, 28, 1, 0});
        tab.push_back('{4'h1, 4, 0, 1, 0, 24, 2, 28, 1, 0});
        tab.push_back('{4'h4, 5, 0, 1, 0, 24, 2, 28, 1, 0});
        tab.push_back('{4'h2, 5, 0, 1, 0, 24, 3, 28, 1, 0});
        tab.push_back('{4'h4, 6, 0, 1, 0, 24, 3, 28, 1, 0});
        tab.push_back('{4'h2, 6, 0, 1, 0, 24, 3, 29, 1, 0});
        tab.push_back('{4'h2, 6, 0, 1, 0, 24, 3, 30, 1, 0});
        tab.push_back('{4'h2, 6, 0, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h2, 6, 0, 1, 0, 24, 3, 1, 1, 0});
        tab.push_back('{4'h1, 6, 0, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h4, 0, 0, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h2, 0, 1, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h4, 1, 1, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h4, 2, 1, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h4, 3, 1, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h4, 4, 1, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h4, 5, 1, 1, 0, 24, 3, 31, 1, 0});
        tab.push_back('{4'h1, 5, 1, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h4, 6, 1, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h1, 6, 1, 1, 0, 24, 2, 28, 1, 0});
        tab.push_back('{4'h2, 6, 1, 1, 0, 24, 2, 29, 1, 0});
        tab.push_back('{4'h2, 6, 1, 1, 0, 24, 2, 1, 1, 0});
        tab.push_back('{4'h3, 6, 1, 1, 0, 24, 2, 2, 1, 0});
        tab.push_back('{4'h6, 0, 1, 1, 0, 24, 2, 2, 1, 0});
        tab.push_back('{4'h8, 0, 1, 1, 0, 24, 2, 2, 0, 1});
        tab.push_back('{4'h0, 0, 1, 1, 0, 24, 2, 2, 0, 0});

        model_reset();
        set_cur(0, 1, 0, 0, 20, 24, 2, 29);

        // Reset state
        do_reset();
        check("rst_state", dut_pk(), pk(0, 0, 12, 0, 0, 1, 1, 0, 0));
        check("rst_blink", 64'(blink), 64'd0);
        check_all("rst_model");

        // Table-driven edit sequence
        press(4'h8);
        check("entry", dut_pk(), pk(1, 0, 1, 0, 24, 2, 29, 1, 0));
        foreach (tab[i]) begin
            press(tab[i].btn);
            check($sformatf("vec[%0d]", i), dut_pk(),
                  pk(tab[i].f, tab[i].a, tab[i].h, tab[i].mi, tab[i].y, tab[i].mo,
                     tab[i].d, tab[i].act, tab[i].ld));
        end

        // Commit: PM 11:59:58 2025-03-25, hour up, commit
        do_reset();
        set_cur(1, 11, 59, 58, 20, 25, 3, 25);
        press(4'h8);
        press(4'h2);
        load_cnt = 0;
        press(4'h8);
        check("commit_vals", dut_pk(), pk(1, 1, 12, 59, 25, 3, 25, 0, 1));
        check("commit_sec_cent", {48'd0, 8'(d2(set_sec_10d, set_sec_1d)),
                                  8'(d2(set_c_10d, set_c_1d))}, {48'd0, 8'd58, 8'd20});
        cyc(); cyc();
        check("commit_once", 64'(load_cnt), 64'd1);
        check_all("commit_model");

        // Timeout with no buttons
        press(4'h8);
        load_cnt = 0;
        for (int i = 0; i < TO - 1; i++) begin tick_press(4'h0); cyc(); end
        check("to_before", 64'(set_active), 64'd1);
        tick_press(4'h0);
        check("to_expire", 64'(set_active), 64'd0);
        check("to_noload", 64'(load_cnt), 64'd0);

        // A button on a tick restarts the count
        press(4'h8);
        for (int i = 0; i < TO - 1; i++) begin tick_press(4'h0); cyc(); end
        tick_press(4'h2);
        for (int i = 0; i < TO - 1; i++) begin tick_press(4'h0); cyc(); end
        check("to_btn_clears", 64'(set_active), 64'd1);
        tick_press(4'h0);
        check("to_expire2", 64'(set_active), 64'd0);
        check("to_noload2", 64'(load_cnt), 64'd0);
        check_all("to_model");

        // Commit coinciding with the timeout tick wins
        press(4'h8);
        for (int i = 0; i < TO - 1; i++) begin tick_press(4'h0); cyc(); end
        tick_press(4'h8);
        check("commit_vs_timeout", {62'd0, set_active, load}, 64'd1);

        // mode+up together: commit only
        do_reset();
        set_cur(0, 7, 30, 0, 20, 24, 6, 15);
        press(4'h8);
        press(4'hA);
        check("mode_up_prio", dut_pk(), pk(1, 0, 7, 30, 24, 6, 15, 0, 1));

        // Reset mid-EDIT
        press(4'h8);
        press(4'h2);
        cyc(); cyc();
        load_cnt = 0;
        reset = 1'b1;
        cyc();
        check("mid_reset", dut_pk(), pk(0, 0, 12, 0, 0, 1, 1, 0, 0));
        reset = 1'b0;
        cyc();
        check("mid_reset_noload", 64'(load_cnt), 64'd0);

        // Blink cadence
        press(4'h8);
        check("blink_entry", 64'(blink), 64'd0);
        for (int k = 1; k <= 2 * BD + 1; k++) begin
            cyc();
            check($sformatf("blink[%0d]", k), 64'(blink), 64'((k / BD) % 2));
        end
        press(4'h8);
        check("blink_exit", 64'(blink), 64'd0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            quiet = (i % 150) >= 110;
            if ($urandom_range(0, 63) == 0) rand_cur();
            reset    = ($urandom_range(0, 999) == 0);
            btn_mode = !quiet && ($urandom_range(0, 39) == 0);
            btn_next = !quiet && ($urandom_range(0, 5) == 0);
            btn_up   = !quiet && ($urandom_range(0, 3) == 0);
            btn_down = !quiet && ($urandom_range(0, 3) == 0);
            tick_1hz = ($urandom_range(0, 2) == 0);
            cyc();
            check_all($sformatf("rand[%0d]", i));
        end
        reset = 1'b0;
        {btn_mode, btn_next, btn_up, btn_down, tick_1hz} = 5'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
